// File: rtl/ifu_imem_responder_pkg.sv
// Shared fetch-path types: FSM states, default code base address and instruction width.
// Imported by the responder, its word array and the IFU.
package ifu_imem_responder_pkg;

    localparam int          INSN_W         = 32;
    localparam logic [31:0] IMEM_BASE_ADDR = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imem_state_e;

endpackage

// File: rtl/ifu_imem_responder_imem_array.sv
// Instruction word store: one combinational read port and one write port.
// A write to the index being read on the same edge is forwarded to the read data (write-first).
module imem_array
    import ifu_imem_responder_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_idx,
    input  logic [INSN_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_idx,
    output logic [INSN_W-1:0] o_rd_data
);

    logic [INSN_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = (i_wr_en && (i_wr_idx == i_rd_idx)) ? i_wr_data : r_mem[i_rd_idx];

endmodule

// File: rtl/ifu_imem_responder.sv
// Fetch responder: one request in flight, response LATENCY cycles after accept, held until resp_ready.
// IMEM_STATS_EN adds fetch/stall counters; req_ready stays low from accept until the response handshake.
module ifu_imem_responder
    import ifu_imem_responder_pkg::*;
#(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR,
    parameter int          LATENCY   = 1,
    parameter int          AW        = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [31:0]       i_req_addr,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [INSN_W-1:0] o_resp_data,
    output logic              o_resp_err,
    input  logic              i_ld_en,
    input  logic [AW-1:0]     i_ld_idx,
    input  logic [INSN_W-1:0] i_ld_data
`ifdef IMEM_STATS_EN
    ,
    output logic [31:0]       o_fetch_cnt,
    output logic [31:0]       o_stall_cnt
`endif
);

    localparam int             CW       = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CW-1:0]  CNT_INIT = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);
    localparam logic [31:0]    SPAN     = 32'(DEPTH * 4);

    imem_state_e       r_state;
    logic [CW-1:0]     r_cnt;
    logic [31:0]       r_addr;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [INSN_W-1:0] r_resp_data;

    logic              w_accept;
    logic              w_load;
    logic              w_err;
    logic [31:0]       w_addr;
    logic [31:0]       w_off;
    logic [AW-1:0]     w_idx;
    logic [INSN_W-1:0] w_rd_data;

    assign o_req_ready  = r_req_ready && i_rst;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_data  = r_resp_data;
    assign o_resp_err   = r_resp_err;

    // With LATENCY==1 the read happens on the accepting edge, before r_addr holds the PC.
    assign w_accept = i_req_valid && o_req_ready;
    assign w_addr   = (r_state == IDLE) ? i_req_addr : r_addr;
    assign w_off    = w_addr - BASE_ADDR;
    assign w_idx    = w_off[AW+1:2];
    assign w_err    = (w_addr[1:0] != 2'b00) || (w_off >= SPAN);
    assign w_load   = ((r_state == IDLE) && w_accept && (LATENCY == 1)) ||
                      ((r_state == WAIT) && (r_cnt == '0));

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk     (i_clk),
        .i_wr_en   (i_ld_en),
        .i_wr_idx  (i_ld_idx),
        .i_wr_data (i_ld_data),
        .i_rd_idx  (w_idx),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr      <= i_req_addr;
                        r_req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (i_resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_load) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= w_err;
                r_resp_data  <= w_err ? '0 : w_rd_data;
            end
        end
    end

`ifdef IMEM_STATS_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_resp_valid && i_resp_ready) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (r_resp_valid && !i_resp_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign o_fetch_cnt = r_fetch_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ifu_imem_responder.sv
// Directed bench for ifu_imem_responder (LATENCY=3, DEPTH=16) with a queue-based response scoreboard.
module tb_ifu_imem_responder;

    localparam int          DEPTH = 16;
    localparam int          LAT   = 3;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        req_valid  = 1'b0;
    logic [31:0] req_addr   = '0;
    logic        resp_ready = 1'b1;
    logic        ld_en      = 1'b0;
    logic [3:0]  ld_idx     = '0;
    logic [31:0] ld_data    = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    ifu_imem_responder #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .LATENCY   (LAT)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_addr   (req_addr),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_data  (resp_data),
        .o_resp_err   (resp_err),
        .i_ld_en      (ld_en),
        .i_ld_idx     (ld_idx),
        .i_ld_data    (ld_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic prev_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: compares every presented response against the head of the queue.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_resp: got resp_valid=1 data %h expected no response (cycle %0d)",
                         resp_data, cyc);
            end else begin
                chk("resp_data", resp_data, q[0].data);
                chk("resp_err", {31'b0, resp_err}, {31'b0, q[0].err});
                chk("rdy_in_resp", {31'b0, req_ready}, 32'd0);
                if (!prev_vld) chk("latency", cyc - q[0].acc, LAT);
                if (resp_ready) void'(q.pop_front());
            end
        end
        prev_vld = (resp_valid === 1'b1);
    end

    task automatic load(input logic [3:0] idx, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = idx; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_chk++;
            $display("FAIL ready_timeout: got req_ready=%b expected 1 within 50 cycles", req_ready);
        end
    endtask

    // Issue one fetch; optionally write idx2 on the edge that reads the array.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic e,
                         input bit col, input logic [31:0] col_d);
        wait_ready();
        req_valid = 1'b1;
        req_addr  = a;
        q.push_back('{d, e, cyc});
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = 32'hFFFF_FFFF;
            chk("rdy_busy", {31'b0, req_ready}, 32'd0);
            if (col && k == LAT - 1) begin
                ld_en = 1'b1; ld_idx = 4'd2; ld_data = col_d;
            end else begin
                ld_en = 1'b0;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", {31'b0, req_ready}, 32'd1);

        load(4'd0,  32'h0000_0413);
        load(4'd1,  32'h0010_0073);
        load(4'd2,  32'h1111_1111);
        load(4'd15, 32'hCAFE_F00D);

        fetch(32'h8000_0000, 32'h0000_0413, 1'b0, 1'b0, '0);
        fetch(32'h8000_0004, 32'h0010_0073, 1'b0, 1'b0, '0);
        fetch(32'h8000_003C, 32'hCAFE_F00D, 1'b0, 1'b0, '0);
        fetch(32'h8000_0002, 32'h0000_0000, 1'b1, 1'b0, '0);
        fetch(32'h7FFF_FFFC, 32'h0000_0000, 1'b1, 1'b0, '0);
        fetch(32'h8000_0040, 32'h0000_0000, 1'b1, 1'b0, '0);

        // Same-edge write to idx2 must be visible in the response.
        fetch(32'h8000_0008, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF);

        // Backpressure, with a write to idx2 while the response is held.
        @(posedge clk); #1 resp_ready = 1'b0;
        fetch(32'h8000_0008, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
        load(4'd2, 32'h2222_2222);
        repeat (4) @(negedge clk);
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_exit_valid", {31'b0, resp_valid}, 32'd0);
        chk("bp_exit_ready", {31'b0, req_ready}, 32'd1);
        fetch(32'h8000_0008, 32'h2222_2222, 1'b0, 1'b0, '0);

        // Reset while the request sits in WAIT: no response may ever appear.
        wait_ready();
        req_valid = 1'b1;
        req_addr  = 32'h8000_0004;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_wait_valid", {31'b0, resp_valid}, 32'd0);
            chk("rst_wait_ready", {31'b0, req_ready}, 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rel_ready", {31'b0, req_ready}, 32'd1);
        fetch(32'h8000_0000, 32'h0000_0413, 1'b0, 1'b0, '0);

        for (int t = 0; t < 50 && q.size() != 0; t++) @(negedge clk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending responses expected 0", q.size());
        end
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
